// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the hex display encoder and the loopback decoder.
// Segment patterns are active-low, bit6 = a .. bit0 = g.
package seg7_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h01;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h4C;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h20;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h0F;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h60;
  localparam logic [SEG_W-1:0] SEG_C = 7'h31;
  localparam logic [SEG_W-1:0] SEG_D = 7'h42;
  localparam logic [SEG_W-1:0] SEG_E = 7'h30;
  localparam logic [SEG_W-1:0] SEG_F = 7'h38;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment to hex-nibble lookup; unknown patterns give nibble 0 and invalid=1.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic [DIGIT_W-1:0] nib,
  output logic               invalid
);

  always_comb begin
    nib     = '0;
    invalid = 1'b0;
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Rebuilds a 32-bit value from a digit-multiplexed active-low 7-segment stream.
// Optional error counter enabled with `define SEG7_ERR_COUNT_EN.
//
// state   | meaning
// IDLE    | waiting for digit 0 to open a frame; other digits ignored
// COLLECT | digits 1..7 expected in order, inter-strobe timeout running
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_DIGITS     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          seg_valid,
  input  logic [SEG_W-1:0]              seg_in,
  input  logic [2:0]                    dig_idx,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value,
  output logic                          frame_valid,
  output logic [NUM_DIGITS-1:0]         err_mask,
  output logic                          seq_err,
  output logic [15:0]                   err_count
);

  localparam int              VAL_W    = DIGIT_W * NUM_DIGITS;
  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [2:0]            exp_q, exp_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [VAL_W-1:0]      asm_q, asm_d, asm_ins;
  logic [NUM_DIGITS-1:0] emask_q, emask_d, emask_ins;
  logic [VAL_W-1:0]      value_d;
  logic [NUM_DIGITS-1:0] err_mask_d;
  logic                  frame_valid_d;
  logic                  seq_err_d;
  logic [DIGIT_W-1:0]    nib;
  logic                  dig_bad;

  seg7_digit_decode u_digit_decode (
    .seg     (seg_in),
    .nib     (nib),
    .invalid (dig_bad)
  );

  // Current word with the incoming digit dropped into its slot.
  always_comb begin
    asm_ins                               = asm_q;
    asm_ins[{dig_idx, 2'b00} +: DIGIT_W]  = nib;
    emask_ins                             = emask_q;
    emask_ins[dig_idx]                    = dig_bad;
  end

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    tmr_d         = tmr_q;
    asm_d         = asm_q;
    emask_d       = emask_q;
    value_d       = value;
    err_mask_d    = err_mask;
    frame_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (seg_valid && dig_idx == 3'd0) begin
          asm_d   = asm_ins;
          emask_d = emask_ins;
          exp_d   = 3'd1;
          tmr_d   = TMR_LOAD;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (seg_valid) begin
          if (dig_idx == exp_q) begin
            if (exp_q == LAST_IDX) begin
              value_d       = asm_ins;
              err_mask_d    = emask_ins;
              frame_valid_d = 1'b1;
              state_d       = IDLE;
            end else begin
              asm_d   = asm_ins;
              emask_d = emask_ins;
              exp_d   = exp_q + 3'd1;
              tmr_d   = TMR_LOAD;
            end
          end else if (dig_idx == 3'd0) begin
            // A fresh digit 0 aborts the partial frame and opens a new one.
            seq_err_d = 1'b1;
            asm_d     = asm_ins;
            emask_d   = emask_ins;
            exp_d     = 3'd1;
            tmr_d     = TMR_LOAD;
          end else begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmr_q == '0) begin
          seq_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      tmr_q       <= '0;
      asm_q       <= '0;
      emask_q     <= '0;
      value       <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      tmr_q       <= tmr_d;
      asm_q       <= asm_d;
      emask_q     <= emask_d;
      value       <= value_d;
      err_mask    <= err_mask_d;
      frame_valid <= frame_valid_d;
      seq_err     <= seq_err_d;
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [15:0] err_count_q;

  // Abort and corrupt-frame events are mutually exclusive per cycle, but count once regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if ((seq_err_d || (frame_valid_d && |err_mask_d)) && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed self-checking bench for seg7_frame_decoder (default and SEG7_ERR_COUNT_EN builds).
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seg_valid;
  logic [6:0]  seg_in;
  logic [2:0]  dig_idx;
  logic [31:0] value;
  logic        frame_valid;
  logic [7:0]  err_mask;
  logic        seq_err;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int se_cnt   = 0;
  int fv0, se0;

`ifdef SEG7_ERR_COUNT_EN
  localparam bit EC_EN = 1'b1;
`else
  localparam bit EC_EN = 1'b0;
`endif

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  always #5 clk = ~clk;

  seg7_frame_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_valid   (seg_valid),
    .seg_in      (seg_in),
    .dig_idx     (dig_idx),
    .value       (value),
    .frame_valid (frame_valid),
    .err_mask    (err_mask),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  // Pulse counters sampled shortly after each falling edge.
  always begin
    @(negedge clk);
    #2;
    if (frame_valid === 1'b1) fv_cnt++;
    if (seq_err === 1'b1) se_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ec_exp(input int n);
    return EC_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] idx, input logic [6:0] seg);
    @(negedge clk);
    seg_valid = v;
    dig_idx   = idx;
    seg_in    = seg;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 3'd0, 7'h7F);
  endtask

  task automatic send_digits(input logic [31:0] w, input int lo, input int hi, input int bad);
    for (int i = lo; i <= hi; i++)
      drive(1'b1, 3'(i), (i == bad) ? 7'h7F : seg_tab[w[4*i +: 4]]);
  endtask

  // Full frame followed by one idle cycle; returns at the cycle frame_valid should be high.
  task automatic send_frame(input logic [31:0] w, input int bad);
    send_digits(w, 0, 7, bad);
    idle(1);
  endtask

  initial begin
    rst_n     = 1'b0;
    seg_valid = 1'b0;
    seg_in    = 7'h7F;
    dig_idx   = 3'd0;
    idle(3);
    chk("rst_value", value, 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Clean frame, back-to-back strobes
    se0 = se_cnt;
    send_frame(32'h12345678, -1);
    chk("f1_frame_valid", 32'(frame_valid), 32'd1);
    chk("f1_value", value, 32'h12345678);
    chk("f1_err_mask", 32'(err_mask), 32'd0);
    idle(1);
    chk("f1_fv_one_cycle", 32'(frame_valid), 32'd0);
    chk("f1_no_seq_err", 32'(se_cnt - se0), 32'd0);

    // Corrupt digit 3
    send_frame(32'h12345678, 3);
    chk("f2_value", value, 32'h12340678);
    chk("f2_err_mask", 32'(err_mask), 32'h08);
    idle(1);
    chk("f2_err_count", 32'(err_count), ec_exp(1));

    send_frame(32'hFEDCBA98, -1);
    chk("f2b_value", value, 32'hFEDCBA98);
    chk("f2b_err_mask", 32'(err_mask), 32'd0);
    idle(1);
    chk("f2b_err_count", 32'(err_count), ec_exp(1));

    // Out-of-order jump 2 -> 5
    fv0 = fv_cnt;
    send_digits(32'hDEADBEEF, 0, 2, -1);
    drive(1'b1, 3'd5, seg_tab[4'hA]);
    idle(1);
    chk("f3_seq_err", 32'(seq_err), 32'd1);
    idle(1);
    chk("f3_seq_err_pulse", 32'(seq_err), 32'd0);
    chk("f3_value_held", value, 32'hFEDCBA98);
    chk("f3_no_frame", 32'(fv_cnt - fv0), 32'd0);
    send_frame(32'hDEADBEEF, -1);
    chk("f3_next_value", value, 32'hDEADBEEF);
    idle(1);
    chk("f3_err_count", 32'(err_count), ec_exp(2));

    // Timeout after TIMEOUT_CYCLES idle cycles
    se0 = se_cnt;
    fv0 = fv_cnt;
    send_digits(32'h12345678, 0, 3, -1);
    idle(64);
    chk("f4_timeout_not_early", 32'(seq_err), 32'd0);
    idle(1);
    chk("f4_timeout_seq_err", 32'(seq_err), 32'd1);
    idle(10);
    chk("f4_timeout_once", 32'(se_cnt - se0), 32'd1);
    chk("f4_timeout_no_frame", 32'(fv_cnt - fv0), 32'd0);
    chk("f4_value_held", value, 32'hDEADBEEF);
    chk("f4_err_count", 32'(err_count), ec_exp(3));

    // Gap one short of the timeout still completes
    se0 = se_cnt;
    send_digits(32'h0BADF00D, 0, 3, -1);
    idle(63);
    send_digits(32'h0BADF00D, 4, 7, -1);
    idle(1);
    chk("f4b_frame_valid", 32'(frame_valid), 32'd1);
    chk("f4b_value", value, 32'h0BADF00D);
    idle(1);
    chk("f4b_no_seq_err", 32'(se_cnt - se0), 32'd0);

    // Digit 0 mid-frame restarts
    se0 = se_cnt;
    send_digits(32'h11111111, 0, 4, -1);
    send_digits(32'h89ABCDEF, 0, 0, -1);
    idle(1);
    chk("f5_seq_err", 32'(seq_err), 32'd1);
    idle(1);
    send_digits(32'h89ABCDEF, 1, 7, -1);
    idle(1);
    chk("f5_frame_valid", 32'(frame_valid), 32'd1);
    chk("f5_value", value, 32'h89ABCDEF);
    idle(1);
    chk("f5_seq_err_count", 32'(se_cnt - se0), 32'd1);
    chk("f5_err_count", 32'(err_count), ec_exp(4));

    // Next frame's digit 0 in the frame_valid cycle
    fv0 = fv_cnt;
    send_digits(32'h13579BDF, 0, 7, -1);
    send_digits(32'h2468ACE0, 0, 0, -1);
    chk("bb_first_fv", 32'(frame_valid), 32'd1);
    chk("bb_first_value", value, 32'h13579BDF);
    send_digits(32'h2468ACE0, 1, 7, -1);
    idle(1);
    chk("bb_second_value", value, 32'h2468ACE0);
    idle(1);
    chk("bb_frame_count", 32'(fv_cnt - fv0), 32'd2);

    // Reset in the middle of a frame
    fv0 = fv_cnt;
    se0 = se_cnt;
    send_digits(32'h55555555, 0, 3, -1);
    @(negedge clk);
    seg_valid = 1'b1;
    dig_idx   = 3'd4;
    seg_in    = seg_tab[4'h5];
    rst_n     = 1'b0;
    #1;
    chk("r6_value", value, 32'h0);
    chk("r6_err_mask", 32'(err_mask), 32'd0);
    chk("r6_err_count", 32'(err_count), 32'd0);
    idle(2);
    rst_n = 1'b1;
    send_digits(32'h33333333, 3, 3, -1);
    send_digits(32'h33333333, 3, 3, -1);
    drive(1'b1, 3'd5, seg_tab[4'h1]);
    idle(3);
    chk("r6_no_frame", 32'(fv_cnt - fv0), 32'd0);
    chk("r6_no_seq_err", 32'(se_cnt - se0), 32'd0);
    chk("r6_value_after", value, 32'h0);
    send_frame(32'h90000000, -1);
    chk("r6_post_value", value, 32'h90000000);
    chk("r6_post_err_mask", 32'(err_mask), 32'd0);
    idle(1);
    chk("r6_post_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
